// File: rtl/hall_input_filter.sv
// Hall sensor front end: synchroniser, stability debounce, illegal-code and adjacency checks.
// Define HALL_FILTER_DIAG_EN to build the invalid/skip counters and the sticky fault flag.
module hall_input_filter #(
  parameter int clk_freq_hz = 27_000_000,
  parameter int filter_us   = 2,
  parameter int diag_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            hall_raw,
  input  logic                  fault_clear,
  output logic [2:0]            hall_values,
  output logic                  hall_valid,
  output logic                  hall_strobe,
  output logic [diag_width-1:0] invalid_count,
  output logic [diag_width-1:0] skip_count,
  output logic                  fault
);

  localparam int stable_ticks = clk_freq_hz / 1_000_000 * filter_us;
  localparam int cnt_w = (stable_ticks < 2) ? 1 : $clog2(stable_ticks);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(stable_ticks - 1);

  if (stable_ticks < 2) begin : g_bad_ticks
    $error("hall_input_filter: stable_ticks must be >= 2");
  end

  // Code bit order {C, B, A}
  localparam logic [2:0] HALL_A  = 3'b001;
  localparam logic [2:0] HALL_B  = 3'b010;
  localparam logic [2:0] HALL_C  = 3'b100;
  localparam logic [2:0] HALL_AB = 3'b011;
  localparam logic [2:0] HALL_BC = 3'b110;
  localparam logic [2:0] HALL_AC = 3'b101;

  function automatic logic [2:0] hall_next(input logic [2:0] h);
    case (h)
      HALL_AC: return HALL_A;
      HALL_A:  return HALL_AB;
      HALL_AB: return HALL_B;
      HALL_B:  return HALL_BC;
      HALL_BC: return HALL_C;
      HALL_C:  return HALL_AC;
      default: return h;
    endcase
  endfunction

  function automatic logic [2:0] hall_prev(input logic [2:0] h);
    case (h)
      HALL_AC: return HALL_C;
      HALL_A:  return HALL_AC;
      HALL_AB: return HALL_A;
      HALL_B:  return HALL_AB;
      HALL_BC: return HALL_B;
      HALL_C:  return HALL_BC;
      default: return h;
    endcase
  endfunction

  typedef enum logic [1:0] {S_INIT, S_LOCKED, S_FAULT} state_t;

  logic [2:0]       sync_q1, hall_sync;
  logic [2:0]       cand, last_eval;
  logic [cnt_w-1:0] cnt;
  state_t           state, state_nxt;
  logic [2:0]       values_nxt;
  logic             valid_nxt, strobe_nxt;
  logic             stable_evt, legal, inv_inc, skip_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1   <= '0;
      hall_sync <= '0;
    end else begin
      sync_q1   <= hall_raw;
      hall_sync <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (hall_sync != cand) begin
      cand <= hall_sync;
      cnt  <= '0;
    end else if (cnt < cnt_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  // last_eval makes each distinct stable code fire exactly once, so a glitch
  // that returns to the accepted code re-stabilises silently.
  assign stable_evt = (cnt == cnt_max) && (cand != last_eval);
  assign legal      = (cand != 3'b000) && (cand != 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        last_eval <= '0;
    else if (stable_evt) last_eval <= cand;
  end

  always_comb begin
    state_nxt  = state;
    values_nxt = hall_values;
    valid_nxt  = hall_valid;
    strobe_nxt = 1'b0;
    inv_inc    = 1'b0;
    skip_inc   = 1'b0;
    if (stable_evt) begin
      case (state)
        S_INIT, S_FAULT: begin
          if (legal) begin
            values_nxt = cand;
            valid_nxt  = 1'b1;
            strobe_nxt = 1'b1;
            state_nxt  = S_LOCKED;
          end else begin
            inv_inc = 1'b1;
          end
        end
        S_LOCKED: begin
          if (legal) begin
            values_nxt = cand;
            strobe_nxt = 1'b1;
            skip_inc   = (cand != hall_next(hall_values)) && (cand != hall_prev(hall_values));
          end else begin
            valid_nxt = 1'b0;
            inv_inc   = 1'b1;
            state_nxt = S_FAULT;
          end
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_INIT;
      hall_values <= '0;
      hall_valid  <= 1'b0;
      hall_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      hall_values <= values_nxt;
      hall_valid  <= valid_nxt;
      hall_strobe <= strobe_nxt;
    end
  end

`ifdef HALL_FILTER_DIAG_EN
  // Counters saturate; a coincident clear wins over any increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      invalid_count <= '0;
      skip_count    <= '0;
      fault         <= 1'b0;
    end else if (fault_clear) begin
      invalid_count <= '0;
      skip_count    <= '0;
      fault         <= 1'b0;
    end else begin
      if (inv_inc && (invalid_count != '1)) invalid_count <= invalid_count + 1'b1;
      if (skip_inc && (skip_count != '1))   skip_count    <= skip_count + 1'b1;
      if (inv_inc || skip_inc)              fault         <= 1'b1;
    end
  end
`else
  logic diag_unused;
  assign diag_unused   = ^{inv_inc, skip_inc, fault_clear};
  assign invalid_count = '0;
  assign skip_count    = '0;
  assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_hall_input_filter.sv
// Randomised + directed bench for hall_input_filter with a level-hold reference model and strobe scoreboard.
module tb_hall_input_filter;
  localparam int STABLE = 54;
  localparam int DW     = 3;
  localparam int SAT    = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    hall_raw = 3'b000;
  logic          fault_clear = 1'b0;
  logic [2:0]    hall_values;
  logic          hall_valid, hall_strobe, fault;
  logic [DW-1:0] invalid_count, skip_count;

  hall_input_filter #(.clk_freq_hz(27_000_000), .filter_us(2), .diag_width(DW)) dut (
    .clk(clk), .reset_n(reset_n), .hall_raw(hall_raw), .fault_clear(fault_clear),
    .hall_values(hall_values), .hall_valid(hall_valid), .hall_strobe(hall_strobe),
    .invalid_count(invalid_count), .skip_count(skip_count), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  typedef struct packed { logic [2:0] v; logic ok; } exp_t;
  exp_t expq[$];
  exp_t mon_e;
  int   strobes_exp = 0, strobes_seen = 0;

  // Rotation order AC -> A -> AB -> B -> BC -> C
  logic [2:0] seq [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

  // Reference model: 0 = waiting for first code, 1 = locked, 2 = faulted
  int         m_state = 0;
  logic [2:0] m_vals = 3'b000, m_last = 3'b000;
  logic       m_valid = 1'b0, m_fault = 1'b0;
  int         m_inv = 0, m_skip = 0;

  function automatic int idx(input logic [2:0] v);
    for (int i = 0; i < 6; i++) if (seq[i] == v) return i;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic accept(input logic [2:0] l);
    m_vals = l;
    expq.push_back({l, m_valid});
    strobes_exp++;
  endtask

  task automatic model_eval(input logic [2:0] l);
    int li, d;
    li = idx(l);
    if (li < 0) begin
      if (m_inv < SAT) m_inv++;
      m_fault = 1'b1;
      if (m_state == 1) begin m_valid = 1'b0; m_state = 2; end
    end else if (m_state == 1) begin
      d = (li - idx(m_vals) + 6) % 6;
      if (d != 1 && d != 5) begin
        if (m_skip < SAT) m_skip++;
        m_fault = 1'b1;
      end
      accept(l);
    end else begin
      m_valid = 1'b1;
      m_state = 1;
      accept(l);
    end
  endtask

  task automatic model_hold(input logic [2:0] l, input int n);
    if (n >= STABLE && l != m_last) begin
      m_last = l;
      model_eval(l);
    end
  endtask

  task automatic model_clear();
    m_inv = 0; m_skip = 0; m_fault = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_vals = 3'b000; m_last = 3'b000; m_valid = 1'b0;
    model_clear();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".values"}, int'(hall_values), int'(m_vals));
    check({tag, ".valid"}, int'(hall_valid), int'(m_valid));
`ifdef HALL_FILTER_DIAG_EN
    check({tag, ".invalid_count"}, int'(invalid_count), m_inv);
    check({tag, ".skip_count"}, int'(skip_count), m_skip);
    check({tag, ".fault"}, int'(fault), int'(m_fault));
`else
    check({tag, ".invalid_count"}, int'(invalid_count), 0);
    check({tag, ".skip_count"}, int'(skip_count), 0);
    check({tag, ".fault"}, int'(fault), 0);
`endif
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic step(input logic [2:0] l, input int n, input string tag);
    model_hold(l, n);
    hall_raw = l;
    repeat (n) @(negedge clk);
    if (n >= 80) check_state(tag);
  endtask

  task automatic do_clear();
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    model_clear();
  endtask

  function automatic logic [2:0] far_code(input logic [2:0] v);
    return seq[(idx(v) + 3) % 6];
  endfunction

  always @(negedge clk) begin
    if (reset_n && hall_strobe) begin
      strobes_seen++;
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL strobe_unexpected actual=%b required=no_strobe", hall_values);
      end else begin
        mon_e = expq.pop_front();
        check("strobe.values", int'(hall_values), int'(mon_e.v));
        check("strobe.valid", int'(hall_valid), int'(mon_e.ok));
      end
    end
  end

  initial begin
    int lat, n, i;
    logic [2:0] l;
    repeat (3) @(negedge clk);
    check("reset.strobe", int'(hall_strobe), 0);
    check_state("reset");
    reset_n = 1'b1;

    // First code after reset, with latency measurement
    model_hold(3'b101, 200);
    hall_raw = 3'b101;
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (hall_strobe) begin lat = c; break; end
    end
    check("latency", lat, 56);
    repeat (150) @(negedge clk);
    check_state("init_ac");

    step(3'b001, 200, "fwd_a");
    step(3'b011, 30, "glitch_ab");
    step(3'b001, 200, "glitch_back");
    step(3'b110, 200, "skip_bc");

    do_clear();
    step(3'b010, 200, "to_b");
    step(3'b111, 200, "illegal_111");
    step(3'b110, 200, "recover_bc");

    for (int k = 0; k < 9; k++) step(far_code(m_vals), 200, "sat_skip");

    // Clear lands on the same edge as a skip event
    l = far_code(m_vals);
    model_hold(l, 200);
    model_clear();
    hall_raw = l;
    repeat (56) @(posedge clk);
    @(negedge clk) fault_clear = 1'b1;
    @(posedge clk);
    @(negedge clk) fault_clear = 1'b0;
    repeat (140) @(negedge clk);
    check_state("clear_vs_skip");

    do_clear();
    i = idx(m_vals);
    for (int j = 1; j <= 6; j++) step(seq[(i + j) % 6], 200, "rot_fwd");
    for (int j = 1; j <= 6; j++) step(seq[(i + 6 - j) % 6], 200, "rot_rev");

    // Reset in the middle of a debounce window
    l = far_code(m_vals);
    hall_raw = l;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("midreset.strobe", int'(hall_strobe), 0);
    check_state("midreset");
    reset_n = 1'b1;
    step(l, 200, "post_reset");

    for (int k = 0; k < 120; k++) begin
      do l = 3'($urandom_range(0, 7)); while (l == hall_raw);
      n = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 45) : $urandom_range(80, 250);
      step(l, n, "rand");
      if (n >= 80 && $urandom_range(0, 9) == 0) do_clear();
    end

    repeat (100) @(negedge clk);
    check("queue_empty", expq.size(), 0);
    check("strobe_total", strobes_seen, strobes_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
